// File: rtl/bool_test_pkg.sv
// ---------------------------------------------------------------------------
// bool_test_pkg
// Shared types and helpers for the Boolean gate self-test sequencer.
//   state_t        : sequencer FSM states
//   NUM_VEC        : number of operand combinations in one sweep
//   MASK_W, BIT_*  : width and bit positions of the 5-bit result/mismatch vector
//   golden_result  : expected gate block outputs for a given (a, b)
// ---------------------------------------------------------------------------
package bool_test_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CHECK,
        ST_DONE
    } state_t;

    localparam int NUM_VEC   = 4;
    localparam int MASK_W    = 5;

    localparam int BIT_NOT_A = 4;
    localparam int BIT_NOT_B = 3;
    localparam int BIT_AND   = 2;
    localparam int BIT_OR    = 1;
    localparam int BIT_NAND  = 0;

    // Expected gate block outputs, packed in mismatch-mask bit order.
    function automatic logic [MASK_W-1:0] golden_result(input logic a, input logic b);
        logic [MASK_W-1:0] r;
        r            = '0;
        r[BIT_NOT_A] = ~a;
        r[BIT_NOT_B] = ~b;
        r[BIT_AND]   = a & b;
        r[BIT_OR]    = a | b;
        r[BIT_NAND]  = ~(a & b);
        return r;
    endfunction

endpackage

// File: rtl/bool_self_test_if.sv
// ---------------------------------------------------------------------------
// bool_self_test_if
// Connection between the self-test sequencer and the gate block under test.
//   a_out, b_out                               : operands into the gate block
//   not_a_in, not_b_in, and_in, or_in, nand_in : gate block results
// Modports:
//   master : the sequencer (drives operands, reads results)
//   slave  : the gate block (reads operands, drives results)
// ---------------------------------------------------------------------------
interface bool_self_test_if;

    logic a_out;
    logic b_out;
    logic not_a_in;
    logic not_b_in;
    logic and_in;
    logic or_in;
    logic nand_in;

    modport master (
        output a_out, b_out,
        input  not_a_in, not_b_in, and_in, or_in, nand_in
    );

    modport slave (
        input  a_out, b_out,
        output not_a_in, not_b_in, and_in, or_in, nand_in
    );

endinterface

// File: rtl/bool_self_test_golden.sv
// ---------------------------------------------------------------------------
// bool_golden
// Combinational golden model of the two-input gate block.
//   a, b   : operands currently driven to the gate block
//   result : expected {not_a, not_b, and, or, nand}
// ---------------------------------------------------------------------------
module bool_golden
    import bool_test_pkg::*;
(
    input  logic              a,
    input  logic              b,
    output logic [MASK_W-1:0] result
);

    assign result = golden_result(a, b);

endmodule

// File: rtl/bool_self_test.sv
// ---------------------------------------------------------------------------
// bool_self_test
// Self-test sequencer for the two-input Boolean gate block. Walks the four
// operand combinations (a,b) = 00, 10, 01, 11 for PASSES sweeps, holds each
// for HOLD_CYCLES settle cycles, then checks the gate outputs against a
// golden model.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   start      : run request, only looked at while idle
//   gate       : operand/result connection to the gate block (master side)
//   busy       : run in progress
//   done       : one-cycle end-of-run pulse
//   pass       : last run saw no mismatches (held until the next start)
//   err_count  : vectors with at least one mismatch, saturating
//   fail_vec   : index of the first failing vector
//   fail_mask  : mismatch bits of the first failing vector
// ---------------------------------------------------------------------------
module bool_self_test
    import bool_test_pkg::*;
#(
    parameter int HOLD_CYCLES = 2,
    parameter int PASSES      = 1,
    parameter int CNT_W       = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    bool_self_test_if.master    gate,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [CNT_W-1:0]    err_count,
    output logic [1:0]          fail_vec,
    output logic [MASK_W-1:0]   fail_mask
);

    localparam int HOLD_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int SWEEP_W = (PASSES > 1) ? $clog2(PASSES) : 1;
    localparam logic [HOLD_W-1:0]  HOLD_INIT  = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [SWEEP_W-1:0] LAST_SWEEP = SWEEP_W'(PASSES - 1);

    state_t              state;
    logic [HOLD_W-1:0]   hold;
    logic [1:0]          vec;
    logic [SWEEP_W-1:0]  sweep;
    logic                failed;

    logic [MASK_W-1:0]   expected;
    logic [MASK_W-1:0]   observed;
    logic [MASK_W-1:0]   mask;
    logic [CNT_W-1:0]    err_next;
    logic [1:0]          vec_next;
    logic                last_vec;

    bool_golden u_golden (
        .a      (gate.a_out),
        .b      (gate.b_out),
        .result (expected)
    );

    // Compare what the gate block returns for the operands currently on
    // a_out/b_out, and work out the counter/vector values the CHECK state
    // would move to. The pass flag is decided from err_next so the last
    // vector's result is included on the very edge that enters DONE.
    always_comb begin
        observed = '0;
        observed[BIT_NOT_A] = gate.not_a_in;
        observed[BIT_NOT_B] = gate.not_b_in;
        observed[BIT_AND]   = gate.and_in;
        observed[BIT_OR]    = gate.or_in;
        observed[BIT_NAND]  = gate.nand_in;
        mask     = observed ^ expected;
        err_next = err_count;
        if (mask != '0 && err_count != '1) begin
            err_next = err_count + CNT_W'(1);
        end
        vec_next = vec + 2'd1;
        last_vec = (vec == 2'(NUM_VEC - 1)) && (sweep == LAST_SWEEP);
    end

    // Sequencer FSM. Every output is registered here: operands are only
    // updated when entering SETTLE or DONE, and results are cleared only when
    // a new run is accepted so they stay readable between runs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            hold       <= '0;
            vec        <= '0;
            sweep      <= '0;
            failed     <= 1'b0;
            gate.a_out <= 1'b0;
            gate.b_out <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_vec   <= '0;
            fail_mask  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        err_count  <= '0;
                        fail_vec   <= '0;
                        fail_mask  <= '0;
                        pass       <= 1'b0;
                        failed     <= 1'b0;
                        vec        <= '0;
                        sweep      <= '0;
                        gate.a_out <= 1'b0;
                        gate.b_out <= 1'b0;
                        hold       <= HOLD_INIT;
                        busy       <= 1'b1;
                        state      <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (hold != '0) begin
                        hold <= hold - HOLD_W'(1);
                    end else begin
                        state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    err_count <= err_next;
                    if (mask != '0 && !failed) begin
                        failed    <= 1'b1;
                        fail_vec  <= vec;
                        fail_mask <= mask;
                    end
                    if (last_vec) begin
                        done       <= 1'b1;
                        busy       <= 1'b0;
                        gate.a_out <= 1'b0;
                        gate.b_out <= 1'b0;
                        pass       <= (err_next == '0) && !failed && (mask == '0);
                        state      <= ST_DONE;
                    end else begin
                        vec        <= vec_next;
                        if (vec == 2'(NUM_VEC - 1)) begin
                            sweep <= sweep + SWEEP_W'(1);
                        end
                        gate.a_out <= vec_next[0];
                        gate.b_out <= vec_next[1];
                        hold       <= HOLD_INIT;
                        state      <= ST_SETTLE;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bool_self_test.sv
// ---------------------------------------------------------------------------
// tb_bool_self_test
// Two sequencer instances (HOLD=2/PASSES=1/CNT_W=8 and HOLD=2/PASSES=2/CNT_W=2)
// each attached to a behavioural gate block that can be made faulty.
// Expected results are derived by sweeping the vectors in plain loops.
// ---------------------------------------------------------------------------
module tb_bool_self_test;

    localparam int H0 = 2, P0 = 1, C0 = 8;
    localparam int H1 = 2, P1 = 2, C1 = 2;

    localparam int M_NONE = 0, M_NAND_TIED = 1, M_OR_STUCK = 2, M_INVERT = 3, M_RANDOM = 4;

    typedef struct packed {
        logic       a;
        logic       b;
        logic       busy;
        logic       done;
        logic       pass;
        logic [7:0] err;
        logic [1:0] fvec;
        logic [4:0] fmask;
    } obs_t;

    logic clk;
    logic rst_n;
    logic start0, start1;
    logic busy0, done0, pass0, busy1, done1, pass1;
    logic [C0-1:0] err0;
    logic [C1-1:0] err1;
    logic [1:0] fvec0, fvec1;
    logic [4:0] fmask0, fmask1;

    int mode0, mode1;
    logic [3:0][4:0] inj0, inj1;

    int tests_run;
    int tests_failed;

    bool_self_test_if g0 ();
    bool_self_test_if g1 ();

    bool_self_test #(.HOLD_CYCLES(H0), .PASSES(P0), .CNT_W(C0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .gate(g0.master),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
        .fail_vec(fvec0), .fail_mask(fmask0)
    );

    bool_self_test #(.HOLD_CYCLES(H1), .PASSES(P1), .CNT_W(C1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .gate(g1.master),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .fail_vec(fvec1), .fail_mask(fmask1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // True gate function, order {not_a, not_b, and, or, nand}.
    function automatic logic [4:0] truth(input logic a, input logic b);
        return {~a, ~b, a & b, a | b, ~(a & b)};
    endfunction

    // Behavioural gate block with selectable faults.
    function automatic logic [4:0] gate_out(input int mode, input logic [3:0][4:0] inj,
                                            input logic a, input logic b);
        logic [4:0] r;
        r = truth(a, b);
        case (mode)
            M_NAND_TIED: r[0] = a & b;
            M_OR_STUCK:  r[1] = 1'b0;
            M_INVERT:    r = ~r;
            M_RANDOM:    r = r ^ inj[{b, a}];
            default:     r = r;
        endcase
        return r;
    endfunction

    // Gate blocks attached to each sequencer.
    always_comb begin
        {g0.not_a_in, g0.not_b_in, g0.and_in, g0.or_in, g0.nand_in} = gate_out(mode0, inj0, g0.a_out, g0.b_out);
        {g1.not_a_in, g1.not_b_in, g1.and_in, g1.or_in, g1.nand_in} = gate_out(mode1, inj1, g1.a_out, g1.b_out);
    end

    function automatic obs_t get_obs(input int sel);
        obs_t o;
        if (sel == 0) begin
            o.a = g0.a_out; o.b = g0.b_out; o.busy = busy0; o.done = done0; o.pass = pass0;
            o.err = 8'(err0); o.fvec = fvec0; o.fmask = fmask0;
        end else begin
            o.a = g1.a_out; o.b = g1.b_out; o.busy = busy1; o.done = done1; o.pass = pass1;
            o.err = 8'(err1); o.fvec = fvec1; o.fmask = fmask1;
        end
        return o;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: sweep every vector of every pass and tally mismatches.
    task automatic expectedRun(input int mode, input logic [3:0][4:0] inj, input int passes,
                               input int cnt_max, output int e_err, output int e_vec,
                               output int e_mask, output int e_pass);
        logic [4:0] m;
        bit got_first;
        e_err = 0; e_vec = 0; e_mask = 0; got_first = 0;
        for (int p = 0; p < passes; p++) begin
            for (int i = 0; i < 4; i++) begin
                m = gate_out(mode, inj, i[0], i[1]) ^ truth(i[0], i[1]);
                if (m != 0) begin
                    if (e_err < cnt_max) e_err++;
                    if (!got_first) begin
                        got_first = 1;
                        e_vec = i;
                        e_mask = int'(m);
                    end
                end
            end
        end
        e_pass = (e_err == 0) ? 1 : 0;
    endtask

    // Pulse start, follow the run edge by edge and check the result.
    task automatic applyStimulus(input int sel, input string tag);
        int hc, pc, lat, cyc, trace_err, v;
        int e_err, e_vec, e_mask, e_pass;
        obs_t o;
        hc = (sel == 0) ? H0 : H1;
        pc = (sel == 0) ? P0 : P1;
        lat = 4 * pc * (hc + 1);
        if (sel == 0) expectedRun(mode0, inj0, P0, (1 << C0) - 1, e_err, e_vec, e_mask, e_pass);
        else          expectedRun(mode1, inj1, P1, (1 << C1) - 1, e_err, e_vec, e_mask, e_pass);
        if (sel == 0) start0 = 1'b1; else start1 = 1'b1;
        @(negedge clk);
        start0 = 1'b0; start1 = 1'b0;
        cyc = 0;
        trace_err = 0;
        o = get_obs(sel);
        while (!o.done && cyc < lat + 8) begin
            v = (cyc / (hc + 1)) % 4;
            if ({o.a, o.b, o.busy} != {v[0], v[1], 1'b1}) trace_err++;
            @(negedge clk);
            cyc++;
            o = get_obs(sel);
        end
        checkOutput({tag, "_latency"}, cyc, lat);
        checkOutput({tag, "_trace"}, trace_err, 0);
        checkOutput({tag, "_done_ab_busy"}, {o.a, o.b, o.busy}, 3'b000);
        checkOutput({tag, "_err"}, o.err, e_err);
        checkOutput({tag, "_fvec"}, o.fvec, e_vec);
        checkOutput({tag, "_fmask"}, o.fmask, e_mask);
        checkOutput({tag, "_pass"}, o.pass, e_pass);
        @(negedge clk);
        o = get_obs(sel);
        checkOutput({tag, "_done_pulse"}, o.done, 1'b0);
        repeat (2) @(negedge clk);
        o = get_obs(sel);
        checkOutput({tag, "_pass_hold"}, o.pass, e_pass);
    endtask

    initial begin
        obs_t o;
        int cyc, d1, d2, ndone, busy_a, busy_b;
        tests_run = 0;
        tests_failed = 0;
        mode0 = M_NONE; mode1 = M_NONE;
        inj0 = '0; inj1 = '0;
        start0 = 1'b0; start1 = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset0", 32'(get_obs(0)), 32'd0);
        checkOutput("reset1", 32'(get_obs(1)), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] directed runs");
        mode0 = M_NONE;      applyStimulus(0, "clean");
        mode0 = M_NAND_TIED; applyStimulus(0, "nand_tied");
        mode0 = M_OR_STUCK;  applyStimulus(0, "or_stuck");
        mode1 = M_INVERT;    applyStimulus(1, "invert_sat");

        $display("[TB] random runs");
        for (int it = 0; it < 8; it++) begin
            logic [3:0][4:0] r;
            for (int i = 0; i < 4; i++) r[i] = ($urandom_range(0, 1) == 1) ? 5'($urandom) : 5'd0;
            if (it % 2 == 0) begin mode0 = M_RANDOM; inj0 = r; applyStimulus(0, "rand0"); end
            else             begin mode1 = M_RANDOM; inj1 = r; applyStimulus(1, "rand1"); end
        end

        $display("[TB] start held high");
        mode0 = M_NAND_TIED;
        start0 = 1'b1;
        cyc = 0; d1 = -1; d2 = -1; ndone = 0; busy_a = -1; busy_b = -1;
        while (d2 < 0 && cyc < 60) begin
            @(negedge clk);
            o = get_obs(0);
            if (o.done) begin
                ndone++;
                if (d1 < 0) begin d1 = cyc; mode0 = M_NONE; end
                else d2 = cyc;
            end
            if (d1 >= 0 && cyc == d1 + 1) busy_a = int'(o.busy);
            if (d1 >= 0 && cyc == d1 + 2) begin busy_b = int'(o.busy); start0 = 1'b0; end
            if (d2 < 0) cyc++;
        end
        start0 = 1'b0;
        checkOutput("held_first_done", d1, 12);
        checkOutput("held_busy_in_idle", busy_a, 0);
        checkOutput("held_restart", busy_b, 1);
        checkOutput("held_second_done", d2, 26);
        checkOutput("held_done_count", ndone, 2);
        checkOutput("held_second_results", {o.pass, o.err, o.fvec, o.fmask}, {1'b1, 15'd0});
        repeat (3) @(negedge clk);
        checkOutput("held_no_third_run", get_obs(0).busy, 1'b0);

        $display("[TB] reset mid-run");
        mode0 = M_NAND_TIED;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (5) @(negedge clk);
        o = get_obs(0);
        checkOutput("pre_rst_err", o.err, 1);
        checkOutput("pre_rst_a", o.a, 1'b1);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_outputs", 32'(get_obs(0)), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mode0 = M_NONE;
        @(negedge clk);
        applyStimulus(0, "post_rst");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
